// File: rtl/ofmap_output_serializer_if.sv
// ofmap_output_serializer_if
//   Groups the two bundles that the serializer drives. One is the buffer read port. The other is
//   the 16-bit valid/ready output stream.
//   master : serializer side (drives ren/raddr/output_*, receives rdata/output_rdy)
//   slave  : buffer + downstream side
//   Signals:
//     ren, raddr   buffer read request; rdata returns one cycle after ren
//     output_dat/output_vld/output_rdy  serialized stream
//     output_last  present only when OFMAP_OUT_LAST_EN is defined
interface ofmap_output_serializer_if #(
  parameter int OC0             = 4,
  parameter int BANK_ADDR_WIDTH = 16
);
  logic                       ren;
  logic [BANK_ADDR_WIDTH-1:0] raddr;
  logic [16*OC0-1:0]          rdata;
  logic [15:0]                output_dat;
  logic                       output_vld;
  logic                       output_rdy;
`ifdef OFMAP_OUT_LAST_EN
  logic                       output_last;
`endif

  modport master (
    output ren, raddr, output_dat, output_vld,
`ifdef OFMAP_OUT_LAST_EN
    output output_last,
`endif
    input  rdata, output_rdy
  );

  modport slave (
    input  ren, raddr, output_dat, output_vld,
`ifdef OFMAP_OUT_LAST_EN
    input  output_last,
`endif
    output rdata, output_rdy
  );
endinterface

// File: rtl/ofmap_output_serializer.sv
// ofmap_output_serializer
//   Reads OC0-lane words from the read bank of the ofmap double buffer. It then de-chains each word
//   into 16-bit beats on a valid/ready stream, lane 0 first. Bank hand-over is coordinated with the
//   main FSM through start_new_read_bank / read_bank_ready_to_switch / switch.
//   Ports:
//     clk, rst                   single clock, synchronous active-high reset
//     config_data_ofmap_words    buffer words per bank (N), latched in IDLE on config_done
//     config_done                configuration valid
//     start_new_read_bank        read bank holds fresh data (honoured in WAIT only)
//     switch                     banks switching this cycle (honoured in DONE only)
//     read_bank_ready_to_switch  bank drained; held until switch
//     read_bank_count            completed banks, 0..1 wrapping
//     bus                        ofmap_output_serializer_if.master (buffer read + output stream)
//   Optional feature: define OFMAP_OUT_LAST_EN to add bus.output_last. It marks the final beat of a bank.
module ofmap_output_serializer #(
  parameter int OC0             = 4,
  parameter int BANK_ADDR_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [BANK_ADDR_WIDTH-1:0] config_data_ofmap_words,
  input  logic                       config_done,
  input  logic                       start_new_read_bank,
  input  logic                       switch,
  output logic                       read_bank_ready_to_switch,
  output logic [BANK_ADDR_WIDTH-1:0] read_bank_count,
  ofmap_output_serializer_if.master  bus
);
  localparam int LANE_W = (OC0 > 1) ? $clog2(OC0) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_READ, S_LOAD, S_SHIFT, S_DONE
  } state_t;

  state_t                     state, state_n;
  logic [BANK_ADDR_WIDTH-1:0] cfg_n;
  logic [BANK_ADDR_WIDTH-1:0] addr;
  logic [LANE_W-1:0]          lane;
  logic [16*OC0-1:0]          shreg;

  logic                       fire;
  logic                       last_lane;
  logic                       last_addr;

  assign fire      = (state == S_SHIFT) && bus.output_rdy;
  assign last_lane = (lane == LANE_W'(OC0 - 1));
  // N==0 never reaches the compare; it is short-circuited to DONE from WAIT.
  assign last_addr = (addr == (cfg_n - BANK_ADDR_WIDTH'(1)));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (config_done) state_n = S_WAIT;
      S_WAIT:  if (start_new_read_bank)
                 state_n = (cfg_n == '0) ? S_DONE : S_READ;
      S_READ:  state_n = S_LOAD;
      S_LOAD:  state_n = S_SHIFT;
      S_SHIFT: if (fire && last_lane)
                 state_n = last_addr ? S_DONE : S_READ;
      S_DONE:  if (switch) state_n = S_WAIT;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_n                     <= '0;
      addr                      <= '0;
      lane                      <= '0;
      shreg                     <= '0;
      read_bank_ready_to_switch <= 1'b0;
      read_bank_count           <= '0;
    end else begin
      case (state)
        S_IDLE:  if (config_done) cfg_n <= config_data_ofmap_words;
        S_WAIT:  if (start_new_read_bank) addr <= '0;
        S_LOAD: begin
          shreg <= bus.rdata;
          lane  <= '0;
        end
        S_SHIFT: if (fire) begin
          shreg <= shreg >> 16;
          lane  <= lane + LANE_W'(1);
          if (last_lane && !last_addr) addr <= addr + BANK_ADDR_WIDTH'(1);
        end
        S_DONE:  if (switch) begin
          read_bank_ready_to_switch <= 1'b0;
          read_bank_count <= (read_bank_count == '0) ? BANK_ADDR_WIDTH'(1) : '0;
        end
        default: ;
      endcase
      // Flag is a register so it is clean for the main FSM; raised on the DONE entry edge.
      if (state_n == S_DONE && state != S_DONE) read_bank_ready_to_switch <= 1'b1;
    end
  end

  // Output data changes only on an accepted beat, so it is stable while stalled.
  assign bus.ren        = (state == S_READ);
  assign bus.raddr      = addr;
  assign bus.output_vld = (state == S_SHIFT);
  assign bus.output_dat = (state == S_SHIFT) ? shreg[15:0] : 16'h0;
`ifdef OFMAP_OUT_LAST_EN
  assign bus.output_last = (state == S_SHIFT) && last_lane && last_addr;
`endif
endmodule
